// File: rtl/int_controller_if.sv
// int_controller_if
// Data-memory bus between the jacaranda-8 cpu and the interrupt controller.
//   addr     : data-memory address driven by the cpu
//   w_data   : write data driven by the cpu
//   mem_w_en : write strobe driven by the cpu
//   r_data   : combinational read data returned by the peripheral
// The master modport is the cpu side, the slave modport the peripheral side.
interface int_controller_if;
    logic [7:0] addr;
    logic [7:0] w_data;
    logic       mem_w_en;
    logic [7:0] r_data;

    modport master (output addr, output w_data, output mem_w_en, input r_data);
    modport slave  (input addr, input w_data, input mem_w_en, output r_data);
endinterface

// File: rtl/int_controller.sv
// int_controller
// Memory-mapped interrupt controller sitting in front of the jacaranda-8 cpu.
// Rising edges on the peripheral request lines are latched as pending bits,
// masked, and the lowest-index eligible source is dispatched as a one-cycle
// int_req. Further dispatch is blocked until software writes EOI.
// Ports:
//   clock    : system clock, all state on posedge
//   reset    : asynchronous active-high reset
//   bus      : data-memory bus (slave side), four registers at BASE_ADDR..+3
//              +0 INT_EN, +1 INT_VEC, +2 PENDING (W1C), +3 CAUSE / EOI
//   irq_src  : peripheral request lines, synchronous to clock
//   int_req  : one-cycle interrupt request to the cpu
//   int_en   : INT_EN register to the cpu, bit0 is the global enable
//   int_vec  : handler address (INT_VEC register)
module int_controller #(
    parameter int         N_SRC     = 4,
    parameter logic [7:0] BASE_ADDR = 8'hF4
) (
    input  logic             clock,
    input  logic             reset,
    int_controller_if.slave  bus,
    input  logic [N_SRC-1:0] irq_src,
    output logic             int_req,
    output logic [7:0]       int_en,
    output logic [7:0]       int_vec
);

    // Only the global enable and one mask bit per source are implemented.
    localparam logic [7:0] EN_MASK = 8'((1 << (N_SRC + 1)) - 1);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t           state_q, state_d;
    logic [7:0]       en_reg;
    logic [7:0]       vec_reg;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] prev_src;
    logic [2:0]       cause;
    logic             in_service;

    logic [7:0]       offset;
    logic             hit;
    logic             wr_en_reg, wr_vec, wr_pend, wr_eoi;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] rising;
    logic [N_SRC-1:0] w1c_clr;
    logic [N_SRC-1:0] dispatch_clr;
    logic [2:0]       lowest;
    logic             load_cause, accept, eoi_done;

    // Wrapping subtraction keeps the decode correct for any BASE_ADDR.
    assign offset    = bus.addr - BASE_ADDR;
    assign hit       = (offset[7:2] == 6'd0);
    assign wr_en_reg = bus.mem_w_en && hit && (offset[1:0] == 2'd0);
    assign wr_vec    = bus.mem_w_en && hit && (offset[1:0] == 2'd1);
    assign wr_pend   = bus.mem_w_en && hit && (offset[1:0] == 2'd2);
    assign wr_eoi    = bus.mem_w_en && hit && (offset[1:0] == 2'd3);

    assign eligible = pending & en_reg[N_SRC:1];
    assign rising   = irq_src & ~prev_src;
    assign w1c_clr  = wr_pend ? bus.w_data[N_SRC-1:0] : '0;

    assign int_req = (state_q == REQ);
    assign int_en  = en_reg;
    assign int_vec = vec_reg;

    // Lowest set index wins; scanning downward lets the last hit be the lowest.
    always_comb begin
        lowest = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                lowest = 3'(i);
            end
        end
    end

    // One-hot clear of the dispatched source, only when the cpu accepts.
    always_comb begin
        dispatch_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            dispatch_clr[i] = accept && (cause == 3'(i));
        end
    end

    // Software-visible configuration registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            en_reg  <= 8'd0;
            vec_reg <= 8'd0;
        end else begin
            if (wr_en_reg) begin
                en_reg <= bus.w_data & EN_MASK;
            end
            if (wr_vec) begin
                vec_reg <= bus.w_data;
            end
        end
    end

    // Edge detection and pending bits; a new edge beats any clear on the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_src <= '0;
            pending  <= '0;
        end else begin
            prev_src <= irq_src;
            pending  <= (pending & ~(w1c_clr | dispatch_clr)) | rising;
        end
    end

    // FSM state register plus the cause / in-service status it controls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cause      <= 3'd0;
            in_service <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_cause) begin
                cause <= lowest;
            end
            if (accept) begin
                in_service <= 1'b1;
            end else if (eoi_done) begin
                in_service <= 1'b0;
            end
        end
    end

    // Next-state logic. REQ checks the global enable as it stood before this
    // edge, so clearing it on the IDLE->REQ edge makes the request go unaccepted.
    always_comb begin
        state_d    = state_q;
        load_cause = 1'b0;
        accept     = 1'b0;
        eoi_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_reg[0] && (eligible != '0)) begin
                    load_cause = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (en_reg[0]) begin
                    accept  = 1'b1;
                    state_d = SERVICE;
                end else begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (wr_eoi) begin
                    eoi_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Combinational read-back; addresses outside the window read zero.
    always_comb begin
        bus.r_data = 8'd0;
        if (hit) begin
            case (offset[1:0])
                2'd0:    bus.r_data = en_reg;
                2'd1:    bus.r_data = vec_reg;
                2'd2:    bus.r_data = 8'(pending);
                default: bus.r_data = {in_service, 4'b0000, cause};
            endcase
        end
    end

endmodule
